pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It watches ID, ID/EX and EX/MEM stage state and generates the write-enable, flush and hold controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also runs the req/ack handshake with a variable-latency data memory, redirects the PC on taken branches resolved in MEM, and keeps a stall-cycle performance counter.

Parameters:
TIMEOUT, 64, max cycles in MEM_WAIT without mem_ack before the fatal error state
CNT_W, 16, width of stall_count

Ports:
clock  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
id_rs  in  5  rs field of instruction in IF/ID
id_rt  in  5  rt field of instruction in IF/ID
idex_memRead  in  1  ID/EX holds a load
idex_rd  in  5  destination register of ID/EX instruction
exmem_memRead  in  1  EX/MEM holds a load
exmem_memWrite  in  1  EX/MEM holds a store
exmem_branch  in  1  EX/MEM holds a branch
exmem_ZF  in  1  zero flag latched in EX/MEM
exmem_BNE  in  1  branch is BNE (else BEQ)
exmem_branchAddress  in  7  branch target latched in EX/MEM
mem_ack  in  1  data memory completes current access this cycle
pc_write  out  1  PC load enable
pc_src  out  1  1 = PC loads branch_target
branch_target  out  7  target address to PC mux
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID loads NOP
idex_flush  out  1  ID/EX loads bubble (controls zeroed)
exmem_flush  out  1  EX/MEM loads bubble
pipe_hold  out  1  ID/EX and EX/MEM keep their contents
memwb_bubble  out  1  MEM/WB loads bubble (wb=0)
mem_req  out  1  data memory access request
mem_error  out  1  sticky memory timeout flag
stall_count  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- Async reset: state=RUN, wait counter=0, mem_error=0, stall_count=0. While reset=1 the outputs are forced to: pc_write=0, ifid_write=0, ifid_flush=idex_flush=exmem_flush=1, memwb_bubble=1, pipe_hold=0, mem_req=0, pc_src=0. branch_target always equals exmem_branchAddress.
- Control outputs are combinational (Mealy) from state plus inputs. state, wait counter, mem_error and stall_count update on posedge clock.
- memop = exmem_memRead | exmem_memWrite. taken = exmem_branch & (exmem_ZF ^ exmem_BNE).
- Defaults: pc_write=1, ifid_write=1, all flush/hold/bubble=0, pc_src=0.
- RUN state:
  - mem_req=memop.
  - memop & !mem_ack: memory stall. pc_write=0, ifid_write=0, pipe_hold=1, memwb_bubble=1. Next state MEM_WAIT with counter=1. Branch and load-use are not evaluated this cycle.
  - Otherwise, if taken: pc_src=1, ifid_flush=1, idex_flush=1, exmem_flush=1, pc_write=1. Branch has priority over load-use.
  - Otherwise, if idex_memRead & idex_rd!=0 & (idex_rd==id_rs | idex_rd==id_rt): load-use stall. pc_write=0, ifid_write=0, idex_flush=1. Single bubble.
- MEM_WAIT state:
  - mem_req=1.
  - !mem_ack: same freeze outputs as a memory stall. Counter increments. When counter==TIMEOUT, next state ERR and mem_error set next edge.
  - mem_ack: access completes. Defaults apply, and branch/load-use are evaluated exactly as in RUN this cycle. Next state RUN, counter cleared.
- ERR state: pc_write=0, ifid_write=0, pipe_hold=1, memwb_bubble=1, mem_req=0. The block stays in ERR until reset.
- stall_count increments each non-reset cycle with pc_write=0, including ERR. It holds at 2^CNT_W-1.
- mem_ack while mem_req=0 is ignored.
- Reset asserted mid-MEM_WAIT aborts the access immediately (mem_req drops asynchronously).

Test Plan:
- Load-use: idex_memRead=1, idex_rd=5, id_rs=5 -> exactly 1 cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_count=1. Repeat with idex_rd=0 -> no stall.
- Taken BEQ/BNE: exmem_branch=1, ZF=1, BNE=0, branchAddress=7'h2A -> pc_src=1, branch_target=7'h2A, three flushes=1 for one cycle. ZF=1, BNE=1 -> not taken, no flush.
- Memory wait: exmem_memRead=1, mem_ack low 3 cycles then high -> mem_req high 4 cycles, pipe_hold/memwb_bubble/pc_write=0 for 3 cycles, released on the ack cycle; stall_count=3.
- Ack plus branch simultaneity: in MEM_WAIT, ack and taken in the same cycle -> wait released and pc_src=1 with flushes that same cycle.
- Timeout: TIMEOUT=4, memWrite with no ack -> ERR after 4 wait cycles, mem_error=1 sticky, mem_req=0; async reset mid-cycle clears everything, and outputs show reset values before the next edge.
- Saturation: CNT_W=4, hold a stall 20 cycles -> stall_count stops at 15.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for a 5-stage pipeline.
// It generates the stage enables, flushes and holds. It runs the req/ack
// handshake with a variable-latency data memory, redirects the PC on branches
// resolved in MEM, and counts stall cycles.
module pipeline_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             idex_memRead,
    input  logic [4:0]       idex_rd,
    input  logic             exmem_memRead,
    input  logic             exmem_memWrite,
    input  logic             exmem_branch,
    input  logic             exmem_ZF,
    input  logic             exmem_BNE,
    input  logic [6:0]       exmem_branchAddress,
    input  logic             mem_ack,
    output logic             pc_write,
    output logic             pc_src,
    output logic [6:0]       branch_target,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pipe_hold,
    output logic             memwb_bubble,
    output logic             mem_req,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t            r_state;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic              r_mem_error;
    logic [CNT_W-1:0]  r_stall_count;

    logic w_memop;
    logic w_taken;
    logic w_load_use;
    logic w_freeze;
    logic w_eval;
    logic w_req;

    assign branch_target = exmem_branchAddress;
    assign mem_error     = r_mem_error;
    assign stall_count   = r_stall_count;

    // Classify the cycle: frozen on memory, or free to evaluate branch/load-use.
    always_comb begin
        w_memop    = exmem_memRead | exmem_memWrite;
        w_taken    = exmem_branch & (exmem_ZF ^ exmem_BNE);
        w_load_use = idex_memRead && (idex_rd != 5'd0) &&
                     ((idex_rd == id_rs) || (idex_rd == id_rt));
        w_freeze   = 1'b0;
        w_eval     = 1'b0;
        w_req      = 1'b0;
        case (r_state)
            S_RUN: begin
                w_req = w_memop;
                if (w_memop && !mem_ack) begin
                    w_freeze = 1'b1;
                end else begin
                    w_eval = 1'b1;
                end
            end
            S_WAIT: begin
                w_req = 1'b1;
                if (!mem_ack) begin
                    w_freeze = 1'b1;
                end else begin
                    w_eval = 1'b1;
                end
            end
            S_ERR: begin
                w_freeze = 1'b1;
            end
            default: begin
                w_freeze = 1'b1;
            end
        endcase
    end

    // Drive the pipeline controls; reset overrides everything asynchronously.
    always_comb begin
        pc_write     = 1'b1;
        pc_src       = 1'b0;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        pipe_hold    = 1'b0;
        memwb_bubble = 1'b0;
        mem_req      = 1'b0;
        if (reset) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
            memwb_bubble = 1'b1;
        end else begin
            mem_req = w_req;
            if (w_freeze) begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                pipe_hold    = 1'b1;
                memwb_bubble = 1'b1;
            end else if (w_eval && w_taken) begin
                // A taken branch squashes the three younger instructions.
                pc_src      = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (w_eval && w_load_use) begin
                // Hold PC and IF/ID for one cycle and insert a single bubble.
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end else begin
                pc_write = 1'b1;
            end
        end
    end

    // Memory handshake sequencing, wait counter and sticky timeout flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_wait_cnt  <= '0;
            r_mem_error <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_memop && !mem_ack) begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= WCNT_W'(1);
                    end else begin
                        r_state    <= S_RUN;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        r_state    <= S_RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == WCNT_W'(TIMEOUT)) begin
                        r_state     <= S_ERR;
                        r_mem_error <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
                    end
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (!pc_write && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end else begin
            r_stall_count <= r_stall_count;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboarded testbench for pipeline_ctrl (TIMEOUT=4, CNT_W=4).
module tb_pipeline_ctrl;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int SMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    id_rs = 5'd0, id_rt = 5'd0, idex_rd = 5'd0;
    logic          idex_memRead = 1'b0, exmem_memRead = 1'b0, exmem_memWrite = 1'b0;
    logic          exmem_branch = 1'b0, exmem_ZF = 1'b0, exmem_BNE = 1'b0, mem_ack = 1'b0;
    logic [6:0]    exmem_branchAddress = 7'd0;
    logic          pc_write, pc_src, ifid_write, ifid_flush, idex_flush, exmem_flush;
    logic          pipe_hold, memwb_bubble, mem_req, mem_error;
    logic [6:0]    branch_target;
    logic [CW-1:0] stall_count;

    pipeline_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .idex_memRead(idex_memRead), .idex_rd(idex_rd),
        .exmem_memRead(exmem_memRead), .exmem_memWrite(exmem_memWrite),
        .exmem_branch(exmem_branch), .exmem_ZF(exmem_ZF), .exmem_BNE(exmem_BNE),
        .exmem_branchAddress(exmem_branchAddress), .mem_ack(mem_ack),
        .pc_write(pc_write), .pc_src(pc_src), .branch_target(branch_target),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .pipe_hold(pipe_hold), .memwb_bubble(memwb_bubble),
        .mem_req(mem_req), .mem_error(mem_error), .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       pc_write;
        logic       pc_src;
        logic [6:0] branch_target;
        logic       ifid_write;
        logic       ifid_flush;
        logic       idex_flush;
        logic       exmem_flush;
        logic       pipe_hold;
        logic       memwb_bubble;
        logic       mem_req;
        logic       mem_error;
        logic [3:0] stall_count;
    } exp_t;

    typedef struct packed {
        logic       ack;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ld;
        logic [4:0] rd;
        logic       mrd;
        logic       mwr;
        logic       br;
        logic       zf;
        logic       bne;
        logic [6:0] addr;
    } stim_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   done     = 1'b0;

    // Reference model state: length of the current unacknowledged access
    // (0 = none in progress), sticky error, stall count.
    int m_unacked = 0;
    bit m_err     = 1'b0;
    int m_stalls  = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        mem_ack = s.ack; id_rs = s.rs; id_rt = s.rt; idex_memRead = s.ld;
        idex_rd = s.rd; exmem_memRead = s.mrd; exmem_memWrite = s.mwr;
        exmem_branch = s.br; exmem_ZF = s.zf; exmem_BNE = s.bne;
        exmem_branchAddress = s.addr;
    endtask

    // One clock cycle of normal operation: predict, push, advance the model.
    task automatic cycle(input stim_t s);
        exp_t e;
        bit memop, taken, hazard, accessing, frozen;
        apply(s);
        memop  = s.mrd || s.mwr;
        taken  = s.br && (s.zf != s.bne);
        hazard = s.ld && (s.rd != 0) && (s.rd == s.rs || s.rd == s.rt);
        accessing = (m_unacked > 0) || memop;
        frozen = m_err || (accessing && !s.ack);
        e = '0;
        e.branch_target = s.addr;
        e.pc_write = 1'b1;
        e.ifid_write = 1'b1;
        e.mem_req = !m_err && accessing;
        if (frozen) begin
            e.pc_write = 1'b0; e.ifid_write = 1'b0;
            e.pipe_hold = 1'b1; e.memwb_bubble = 1'b1;
        end else if (taken) begin
            e.pc_src = 1'b1; e.ifid_flush = 1'b1;
            e.idex_flush = 1'b1; e.exmem_flush = 1'b1;
        end else if (hazard) begin
            e.pc_write = 1'b0; e.ifid_write = 1'b0; e.idex_flush = 1'b1;
        end
        e.mem_error = m_err;
        e.stall_count = 4'(m_stalls);
        exp_q.push_back(e);
        if (!e.pc_write) m_stalls = (m_stalls + 1 > SMAX) ? SMAX : m_stalls + 1;
        if (!m_err) begin
            if (frozen) begin
                m_unacked = m_unacked + 1;
                // The access may stay unacknowledged TIMEOUT+1 cycles in total.
                if (m_unacked == TO + 1) m_err = 1'b1;
            end else begin
                m_unacked = 0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    // Assert reset now (mid-cycle) and hold it for n cycles.
    task automatic do_reset(input int n, input stim_t s);
        exp_t e;
        reset = 1'b1;
        m_unacked = 0; m_err = 1'b0; m_stalls = 0;
        for (int i = 0; i < n; i++) begin
            apply(s);
            e = '0;
            e.branch_target = s.addr;
            e.ifid_flush = 1'b1; e.idex_flush = 1'b1; e.exmem_flush = 1'b1;
            e.memwb_bubble = 1'b1;
            exp_q.push_back(e);
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
    endtask

    // Monitor: the outputs of every cycle are compared at the falling edge.
    initial begin
        exp_t a, e;
        forever begin
            @(negedge clock);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {pc_write, pc_src, branch_target, ifid_write, ifid_flush,
                     idex_flush, exmem_flush, pipe_hold, memwb_bubble, mem_req,
                     mem_error, stall_count};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs cycle=%0d actual=%b required=%b (pcw,pcsrc,bt,ifw,iff,idf,exf,hold,bub,req,err,cnt)",
                             cyc, a, e);
                end
            end
        end
    end

    initial begin
        stim_t s;
        stim_t r;
        s = idle();
        @(posedge clock);
        #1;
        do_reset(2, s);
        cycle(idle());

        // Load-use on rs, then rd=0 (no stall), then rt match.
        s = idle(); s.ld = 1'b1; s.rd = 5'd5; s.rs = 5'd5;
        cycle(s); cycle(idle());
        s.rd = 5'd0; s.rs = 5'd0;
        cycle(s); cycle(idle());
        s = idle(); s.ld = 1'b1; s.rd = 5'd9; s.rt = 5'd9; s.rs = 5'd3;
        cycle(s); cycle(idle());

        // Branches: BEQ taken, BNE with ZF=1 not taken, BNE with ZF=0 taken.
        s = idle(); s.br = 1'b1; s.zf = 1'b1; s.addr = 7'h2A;
        cycle(s);
        s.bne = 1'b1;
        cycle(s);
        s.zf = 1'b0; s.addr = 7'h55;
        cycle(s);
        // Branch beats load-use.
        s.ld = 1'b1; s.rd = 5'd7; s.rs = 5'd7;
        cycle(s); cycle(idle());

        // Memory wait: three cycles without ack, then ack.
        s = idle(); s.mrd = 1'b1;
        for (int i = 0; i < 3; i++) cycle(s);
        s.ack = 1'b1;
        cycle(s); cycle(idle());

        // Ack and a taken branch in the same cycle.
        s = idle(); s.mwr = 1'b1; s.ld = 1'b1; s.rd = 5'd4; s.rs = 5'd4;
        cycle(s); cycle(s);
        s.ack = 1'b1; s.br = 1'b1; s.zf = 1'b1; s.addr = 7'h11;
        cycle(s);
        // Ack while no request is ignored.
        s = idle(); s.ack = 1'b1;
        cycle(s); cycle(idle());

        // Timeout into ERR; later ack does not leave it; reset mid-cycle.
        do_reset(1, idle());
        s = idle(); s.mwr = 1'b1;
        for (int i = 0; i < 8; i++) cycle(s);
        s.ack = 1'b1;
        cycle(s); cycle(idle());
        s = idle(); s.mwr = 1'b1;
        #2;
        do_reset(1, s);
        cycle(idle());

        // Saturation: a load-use stall held for 20 cycles.
        s = idle(); s.ld = 1'b1; s.rd = 5'd12; s.rt = 5'd12;
        for (int i = 0; i < 20; i++) cycle(s);
        cycle(idle());

        // Randomized traffic with periodic resets.
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 49) do_reset(1, idle());
            r = idle();
            r.ack  = ($urandom_range(0, 2) != 0);
            r.rs   = 5'($urandom_range(0, 7));
            r.rt   = 5'($urandom_range(0, 7));
            r.ld   = ($urandom_range(0, 2) == 0);
            r.rd   = 5'($urandom_range(0, 7));
            r.mrd  = ($urandom_range(0, 5) == 0);
            r.mwr  = ($urandom_range(0, 7) == 0);
            r.br   = ($urandom_range(0, 3) == 0);
            r.zf   = 1'($urandom_range(0, 1));
            r.bne  = 1'($urandom_range(0, 1));
            r.addr = 7'($urandom_range(0, 127));
            if (i >= 300 && i < 320) r.ack = 1'b0;
            cycle(r);
        end

        @(negedge clock);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
